// File: rtl/store_wr_unit_if.sv
// Bundle of the MEM-stage store request bus and the data-memory write port.
// The slave view belongs to store_wr_unit; the master view is the pipeline/memory side.
interface store_wr_unit_if;
   logic        st_valid;
   logic        st_flush;
   logic [1:0]  st_size;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_we;
   logic        dm_ack;
   logic        exc_ades;
   logic [31:0] bad_vaddr;
   logic        buf_empty;

   modport slave (
      input  st_valid, st_flush, st_size, st_addr, st_data, dm_ack,
      output st_ready, dm_req, dm_addr, dm_wdata, dm_we, exc_ades, bad_vaddr, buf_empty
   );

   modport master (
      output st_valid, st_flush, st_size, st_addr, st_data, dm_ack,
      input  st_ready, dm_req, dm_addr, dm_wdata, dm_we, exc_ades, bad_vaddr, buf_empty
   );
endinterface

// File: rtl/store_wr_unit.sv
// Store write unit: lane-aligns sb/sh/sw data, builds the byte mask, queues stores in a small
// FIFO that drains to data memory over req/ack, and reports misaligned stores as AdES.
module store_wr_unit #(
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   store_wr_unit_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [29:0] wordAddr;
      logic [31:0] wdata;
      logic [3:0]  we;
   } entry_t;

   entry_t        r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [PW:0]   r_cnt;
   logic          r_excAdes;
   logic [31:0]   r_badVaddr;

   logic          w_aligned;
   logic [31:0]   w_wdata;
   logic [3:0]    w_we;
   logic          w_full;
   logic          w_empty;
   logic          w_attempt;
   logic          w_push;
   logic          w_pop;

   // Lane replication and byte mask are formed before the push so the FIFO holds ready-to-send beats.
   always_comb begin
      w_aligned = 1'b0;
      w_wdata   = '0;
      w_we      = '0;
      case (bus.st_size)
         2'b00: begin
            w_aligned = 1'b1;
            w_wdata   = {4{bus.st_data[7:0]}};
            w_we      = 4'b0001 << bus.st_addr[1:0];
         end
         2'b01: begin
            w_aligned = ~bus.st_addr[0];
            w_wdata   = {2{bus.st_data[15:0]}};
            w_we      = 4'b0011 << bus.st_addr[1:0];
         end
         2'b10: begin
            w_aligned = (bus.st_addr[1:0] == 2'b00);
            w_wdata   = bus.st_data;
            w_we      = 4'b1111;
         end
         default: begin
            w_aligned = 1'b0;
         end
      endcase
   end

   assign w_full    = (r_cnt == (PW+1)'(DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_attempt = bus.st_valid & ~bus.st_flush & ~w_full;
   assign w_push    = w_attempt & w_aligned;
   assign w_pop     = ~w_empty & bus.dm_ack;

   // A pop in the same cycle never frees a slot for a push; st_ready depends only on the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_cnt      <= '0;
         r_excAdes  <= 1'b0;
         r_badVaddr <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= '{wordAddr: bus.st_addr[31:2], wdata: w_wdata, we: w_we};
            r_wrPtr        <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         r_cnt     <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
         r_excAdes <= w_attempt & ~w_aligned;
         if (w_attempt & ~w_aligned) begin
            r_badVaddr <= bus.st_addr;
         end
      end
   end

   assign bus.st_ready  = ~w_full;
   assign bus.dm_req    = ~w_empty;
   assign bus.dm_addr   = {r_mem[r_rdPtr].wordAddr, 2'b00};
   assign bus.dm_wdata  = r_mem[r_rdPtr].wdata;
   assign bus.dm_we     = r_mem[r_rdPtr].we;
   assign bus.exc_ades  = r_excAdes;
   assign bus.bad_vaddr = r_badVaddr;
   assign bus.buf_empty = w_empty;
endmodule

// File: tb/tb_store_wr_unit.sv
// Scoreboard bench for store_wr_unit: directed stores push hand-computed memory beats and
// AdES reports into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_store_wr_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] excQ[$];

   store_wr_unit_if bus();

   store_wr_unit #(.DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic nextCycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one store for exactly one cycle, then withdraws it.
   task automatic applyStimulus(input logic flush, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] data);
      bus.st_valid = 1'b1;
      bus.st_flush = flush;
      bus.st_size  = size;
      bus.st_addr  = addr;
      bus.st_data  = data;
      nextCycle(1);
      bus.st_valid = 1'b0;
      bus.st_flush = 1'b0;
   endtask

   task automatic pushExp(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
      exp_t e;
      e.addr  = addr;
      e.wdata = wdata;
      e.we    = we;
      expQ.push_back(e);
   endtask

   task automatic waitEmpty(input string name, input int budget);
      int n;
      n = 0;
      while (bus.buf_empty !== 1'b1 && n < budget) begin
         nextCycle(1);
         n++;
      end
      checkOutput(name, {31'd0, bus.buf_empty}, 32'd1);
   endtask

   // Monitor: every accepted memory beat and every AdES pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.dm_req && bus.dm_ack) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_dm_beat", bus.dm_addr, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("dm_addr", bus.dm_addr, e.addr);
               checkOutput("dm_wdata", bus.dm_wdata, e.wdata);
               checkOutput("dm_we", {28'd0, bus.dm_we}, {28'd0, e.we});
            end
         end
         if (bus.exc_ades) begin
            if (excQ.size() == 0) begin
               checkOutput("unexpected_exc_ades", bus.bad_vaddr, 32'hFFFF_FFFF);
            end else begin
               checkOutput("bad_vaddr", bus.bad_vaddr, excQ.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.st_valid = 1'b0;
      bus.st_flush = 1'b0;
      bus.st_size  = 2'b00;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.dm_ack   = 1'b0;
      nextCycle(2);

      checkOutput("rst_dm_req", {31'd0, bus.dm_req}, 32'd0);
      checkOutput("rst_buf_empty", {31'd0, bus.buf_empty}, 32'd1);
      checkOutput("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
      checkOutput("rst_exc_ades", {31'd0, bus.exc_ades}, 32'd0);
      checkOutput("rst_bad_vaddr", bus.bad_vaddr, 32'd0);
      checkOutput("rst_dm_we", {28'd0, bus.dm_we}, 32'd0);
      checkOutput("rst_dm_addr", bus.dm_addr, 32'd0);
      checkOutput("rst_dm_wdata", bus.dm_wdata, 32'd0);
      rst = 1'b0;
      nextCycle(1);

      // sb to lane 3, checked on the cycle after the push while memory holds off.
      pushExp(32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
      applyStimulus(1'b0, 2'b00, 32'h0000_1003, 32'h0000_00AB);
      checkOutput("sb_lat_dm_req", {31'd0, bus.dm_req}, 32'd1);
      checkOutput("sb_lat_dm_addr", bus.dm_addr, 32'h0000_1000);
      checkOutput("sb_lat_dm_we", {28'd0, bus.dm_we}, 32'h8);
      checkOutput("sb_lat_dm_wdata", bus.dm_wdata, 32'hABAB_ABAB);
      checkOutput("sb_lat_buf_empty", {31'd0, bus.buf_empty}, 32'd0);
      nextCycle(1);
      checkOutput("sb_hold_dm_addr", bus.dm_addr, 32'h0000_1000);
      bus.dm_ack = 1'b1;
      waitEmpty("sb_drain_empty", 10);

      // sh then sw back to back with memory always acking.
      pushExp(32'h0000_2000, 32'h1234_1234, 4'b1100);
      applyStimulus(1'b0, 2'b01, 32'h0000_2002, 32'h0000_1234);
      pushExp(32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
      applyStimulus(1'b0, 2'b10, 32'h0000_2004, 32'hDEAD_BEEF);
      waitEmpty("sh_sw_drain_empty", 10);
      checkOutput("sh_sw_beats_left", expQ.size(), 32'd0);

      // Fill the FIFO with memory stalled; the third word store must wait for a slot.
      bus.dm_ack = 1'b0;
      pushExp(32'h0000_5000, 32'h1111_1111, 4'b1111);
      applyStimulus(1'b0, 2'b10, 32'h0000_5000, 32'h1111_1111);
      pushExp(32'h0000_5004, 32'h2222_2222, 4'b1111);
      applyStimulus(1'b0, 2'b10, 32'h0000_5004, 32'h2222_2222);
      bus.st_valid = 1'b1;
      bus.st_size  = 2'b10;
      bus.st_addr  = 32'h0000_5008;
      bus.st_data  = 32'h3333_3333;
      checkOutput("full_st_ready", {31'd0, bus.st_ready}, 32'd0);
      nextCycle(1);
      checkOutput("full_hold_st_ready", {31'd0, bus.st_ready}, 32'd0);
      checkOutput("full_head_addr", bus.dm_addr, 32'h0000_5000);
      bus.dm_ack = 1'b1;
      nextCycle(1);
      bus.dm_ack = 1'b0;
      checkOutput("slot_freed_st_ready", {31'd0, bus.st_ready}, 32'd1);
      pushExp(32'h0000_5008, 32'h3333_3333, 4'b1111);
      nextCycle(1);
      bus.st_valid = 1'b0;
      checkOutput("third_in_st_ready", {31'd0, bus.st_ready}, 32'd0);
      checkOutput("third_in_head_addr", bus.dm_addr, 32'h0000_5004);
      bus.dm_ack = 1'b1;
      waitEmpty("stall_drain_empty", 10);
      checkOutput("stall_beats_left", expQ.size(), 32'd0);
      bus.dm_ack = 1'b0;

      // Misaligned half, misaligned word and reserved size each raise AdES and push nothing.
      excQ.push_back(32'h0000_3001);
      applyStimulus(1'b0, 2'b01, 32'h0000_3001, 32'h0000_5555);
      checkOutput("ades_sh_pulse", {31'd0, bus.exc_ades}, 32'd1);
      checkOutput("ades_sh_vaddr", bus.bad_vaddr, 32'h0000_3001);
      excQ.push_back(32'h0000_3002);
      applyStimulus(1'b0, 2'b10, 32'h0000_3002, 32'h0000_6666);
      excQ.push_back(32'h0000_3000);
      applyStimulus(1'b0, 2'b11, 32'h0000_3000, 32'h0000_7777);
      checkOutput("ades_size11_pulse", {31'd0, bus.exc_ades}, 32'd1);
      nextCycle(1);
      checkOutput("ades_pulse_ends", {31'd0, bus.exc_ades}, 32'd0);
      checkOutput("ades_vaddr_held", bus.bad_vaddr, 32'h0000_3000);
      checkOutput("ades_no_push", {31'd0, bus.buf_empty}, 32'd1);
      checkOutput("ades_all_seen", excQ.size(), 32'd0);

      // Flushed stores neither push nor report, even when misaligned.
      applyStimulus(1'b1, 2'b10, 32'h0000_4000, 32'h0000_8888);
      checkOutput("flush_no_push", {31'd0, bus.buf_empty}, 32'd1);
      checkOutput("flush_no_dm_req", {31'd0, bus.dm_req}, 32'd0);
      applyStimulus(1'b1, 2'b01, 32'h0000_4001, 32'h0000_9999);
      checkOutput("flush_no_ades", {31'd0, bus.exc_ades}, 32'd0);
      checkOutput("flush_vaddr_kept", bus.bad_vaddr, 32'h0000_3000);
      nextCycle(1);

      // Reset with two stores queued drops them.
      applyStimulus(1'b0, 2'b10, 32'h0000_6000, 32'hAAAA_0000);
      applyStimulus(1'b0, 2'b10, 32'h0000_6004, 32'hBBBB_0000);
      checkOutput("prerst_st_ready", {31'd0, bus.st_ready}, 32'd0);
      rst = 1'b1;
      nextCycle(1);
      checkOutput("midrst_dm_req", {31'd0, bus.dm_req}, 32'd0);
      checkOutput("midrst_buf_empty", {31'd0, bus.buf_empty}, 32'd1);
      checkOutput("midrst_st_ready", {31'd0, bus.st_ready}, 32'd1);
      rst = 1'b0;
      nextCycle(2);
      checkOutput("postrst_dm_req", {31'd0, bus.dm_req}, 32'd0);
      checkOutput("end_beats_left", expQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
